fetch_unit: RTL and testbench

- Instruction-fetch front end sitting directly upstream of the decode/execute data path.
- Owns the fetch PC and drives a synchronous-read instruction memory (1-cycle read latency).
- Buffers returned instructions in a small FIFO and hands {instr, pc} to the data path over a valid/ready handshake.
- Accepts redirects (branch/jump targets) from the data path and squashes stale fetches.

---
 rtl/fetch_unit_pkg.sv | 10 +
 rtl/fetch_unit_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch front end.
// Optional feature macro: FETCH_BYPASS_EN (see fetch_unit.sv).
package fetch_unit_pkg;

    localparam int              XLEN        = 32;
    localparam logic [XLEN-1:0] RESET_PC    = 32'h0000_0000;
    localparam int              INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Instruction buffer: DEPTH-entry synchronous FIFO of {pc, instr}.
// Flush empties the buffer at the clock edge and overrides push/pop.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, drives a 1-cycle imem, buffers {instr, pc}.
// Macro FETCH_BYPASS_EN: present a response straight through when the buffer is empty.
module fetch_unit #(
    parameter int              XLEN     = fetch_unit_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = fetch_unit_pkg::RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    import fetch_unit_pkg::*;

    localparam int              CW   = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   req_pc_q;
    logic [XLEN-1:0]   base;
    logic              inflight_q;
    logic [CW-1:0]     count;
    logic [CW:0]       occ;
    logic [2*XLEN-1:0] head;
    logic [2*XLEN-1:0] sel;
    logic              empty;
    logic              resp_ok;
    logic              push;
    logic              pop;
    logic              deq;

    assign empty = (count == '0);
    // A response landing in a redirect cycle is stale; the flush discards it.
    assign resp_ok = inflight_q & ~redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign out_valid = ~redirect_valid & (~empty | resp_ok);
    assign sel       = empty ? {req_pc_q, imem_rdata} : head;
    assign push      = resp_ok & ~(empty & out_ready);
    assign pop       = deq & ~empty;
`else
    assign out_valid = ~redirect_valid & ~empty;
    assign sel       = head;
    assign push      = resp_ok;
    assign pop       = deq;
`endif

    assign deq = out_valid & out_ready;
    assign {out_pc, out_instr} = out_valid ? sel : '0;

    assign occ = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(deq);
    assign imem_en = ~rst & (redirect_valid | (occ < (CW+1)'(DEPTH)));
    assign base = redirect_valid ? redirect_pc : pc_q;
    assign imem_addr = {base[XLEN-1:2], 2'b00};
    assign pc_d = imem_addr + STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= imem_en;
            if (imem_en) begin
                pc_q     <= pc_d;
                req_pc_q <= imem_addr;
            end
        end
    end

    fetch_fifo #(
        .W     (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i ({req_pc_q, imem_rdata}),
        .head_o  (head),
        .count_o (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, stall, redirects, reset mid-flight.
// Build with FETCH_BYPASS_EN defined to exercise the 1-cycle bypass path.
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int          checks = 0;
    int          failures = 0;
    int          nhs;
    logic [31:0] exp_pc;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    // imem model: 1-cycle read, word = address tagged with 0x13.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr | 32'h13;
    end

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (imem_en !== 1'b0) begin
            failures++; $display("FAIL reset_imem_en got=%b exp=0", imem_en);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_instr !== 32'h0 || out_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_out_data got=%h/%h exp=0/0", out_instr, out_pc);
        end
    endtask

    task automatic test_stream();
        exp_pc = 32'h0;
        nhs = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                rst = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            checks++;
            if (imem_en !== 1'b1 || imem_addr !== 32'(4*k)) begin
                failures++;
                $display("FAIL stream_issue k=%0d got=%b/%h exp=1/%h",
                         k, imem_en, imem_addr, 32'(4*k));
            end
            checks++;
            if (out_valid !== (k >= LAT)) begin
                failures++;
                $display("FAIL stream_valid k=%0d got=%b exp=%b", k, out_valid, k >= LAT);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_pc !== exp_pc || out_instr !== (exp_pc | 32'h13)) begin
                    failures++;
                    $display("FAIL stream_data got=%h/%h exp=%h/%h",
                             out_pc, out_instr, exp_pc, exp_pc | 32'h13);
                end
                exp_pc += 4;
                nhs++;
            end
        end
        checks++;
        if (nhs != 10 - LAT) begin
            failures++; $display("FAIL stream_count got=%0d exp=%0d", nhs, 10 - LAT);
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc ||
                out_instr !== (exp_pc | 32'h13)) begin
                failures++;
                $display("FAIL stall_hold k=%0d got=%b/%h exp=1/%h", k, out_valid, out_pc, exp_pc);
            end
            if (k >= 2) begin
                checks++;
                if (imem_en !== 1'b0) begin
                    failures++; $display("FAIL stall_imem_en k=%0d got=%b exp=0", k, imem_en);
                end
            end
        end
        nhs = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (out_pc !== exp_pc || out_instr !== (exp_pc | 32'h13)) begin
                    failures++;
                    $display("FAIL resume_data got=%h/%h exp=%h", out_pc, out_instr, exp_pc);
                end
                exp_pc += 4;
                nhs++;
            end
        end
        checks++;
        if (nhs != 8) begin
            failures++; $display("FAIL resume_count got=%0d exp=8", nhs);
        end
    endtask

    task automatic test_redirect_full();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            #1;
        end
        checks++;
        if (imem_en !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL full_state got en=%b v=%b exp en=0 v=1", imem_en, out_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL redir_mask got=%b exp=0", out_valid);
        end
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL redir_issue got=%b/%h exp=1/00000100", imem_en, imem_addr);
        end
        exp_pc = 32'h100;
        nhs = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== (k >= LAT)) begin
                failures++;
                $display("FAIL redir_valid k=%0d got=%b exp=%b", k, out_valid, k >= LAT);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_pc !== exp_pc || out_instr !== (exp_pc | 32'h13)) begin
                    failures++;
                    $display("FAIL redir_data got=%h/%h exp=%h", out_pc, out_instr, exp_pc);
                end
                exp_pc += 4;
                nhs++;
            end
        end
        checks++;
        if (nhs != 7 - LAT) begin
            failures++; $display("FAIL redir_count got=%0d exp=%0d", nhs, 7 - LAT);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        #1;
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 32'h100 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL misalign_issue got=%b/%h v=%b exp=1/00000100 v=0",
                     imem_en, imem_addr, out_valid);
        end
        exp_pc = 32'h100;
        nhs = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (out_pc !== exp_pc || out_instr !== (exp_pc | 32'h13)) begin
                    failures++;
                    $display("FAIL misalign_data got=%h/%h exp=%h", out_pc, out_instr, exp_pc);
                end
                exp_pc += 4;
                nhs++;
            end
        end
        checks++;
        if (nhs != 6 - LAT) begin
            failures++; $display("FAIL misalign_count got=%0d exp=%0d", nhs, 6 - LAT);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        #1;
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 32'h200) begin
            failures++; $display("FAIL b2b_first got=%b/%h exp=1/00000200", imem_en, imem_addr);
        end
        @(negedge clk);
        redirect_pc = 32'h300;
        #1;
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 32'h300 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second got=%b/%h v=%b exp=1/00000300 v=0",
                     imem_en, imem_addr, out_valid);
        end
        exp_pc = 32'h300;
        nhs = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== (k >= LAT)) begin
                failures++;
                $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, out_valid, k >= LAT);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_pc !== exp_pc || out_instr !== (exp_pc | 32'h13)) begin
                    failures++;
                    $display("FAIL b2b_data got=%h/%h exp=%h", out_pc, out_instr, exp_pc);
                end
                exp_pc += 4;
                nhs++;
            end
        end
        checks++;
        if (nhs != 7 - LAT) begin
            failures++; $display("FAIL b2b_count got=%0d exp=%0d", nhs, 7 - LAT);
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_en !== 1'b0) begin
            failures++;
            $display("FAIL midrst_now got v=%b en=%b exp 0/0", out_valid, imem_en);
        end
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0) begin
            failures++; $display("FAIL midrst_hold got v=%b pc=%h exp 0/0", out_valid, out_pc);
        end
        exp_pc = fetch_unit_pkg::RESET_PC;
        nhs = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) rst = 1'b0;
            #1;
            if (k == 0) begin
                checks++;
                if (imem_en !== 1'b1 || imem_addr !== fetch_unit_pkg::RESET_PC) begin
                    failures++;
                    $display("FAIL midrst_restart got=%b/%h exp=1/%h",
                             imem_en, imem_addr, fetch_unit_pkg::RESET_PC);
                end
            end
            checks++;
            if (out_valid !== (k >= LAT)) begin
                failures++;
                $display("FAIL midrst_valid k=%0d got=%b exp=%b", k, out_valid, k >= LAT);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_pc !== exp_pc || out_instr !== (exp_pc | 32'h13)) begin
                    failures++;
                    $display("FAIL midrst_data got=%h/%h exp=%h", out_pc, out_instr, exp_pc);
                end
                exp_pc += 4;
                nhs++;
            end
        end
        checks++;
        if (nhs != 6 - LAT) begin
            failures++; $display("FAIL midrst_count got=%0d exp=%0d", nhs, 6 - LAT);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_misaligned();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
